return_stack_unit: RTL and testbench

- Hardware return-address stack at the receiving end of the write-control strobes: consumes the StackPush/StackPop pulses and supplies the return address to the PC-source mux.
- JAL pushes PC+1; a stop/return pops, and the popped address is held stable for the following PcWrite cycle.
- Sits between the write-control FSM and the fetch-stage PC register; LIFO storage with full/empty status and sticky error flags.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/stack_ram.sv | 28 ++
 rtl/return_stack_unit.sv | 142 ++++++++++++++
 tb/tb_return_stack_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the return-address stack and its neighbours.
//   AW_DEFAULT / DEPTH_DEFAULT : default address width and stack depth
//   PTR_W_DEFAULT              : stack-pointer width for the default depth
//   stk_op_e                   : decoded stack operation (one per cycle)
package cpu_pkg;

    localparam int unsigned AW_DEFAULT    = 32;
    localparam int unsigned DEPTH_DEFAULT = 8;
    // One extra bit so a full stack (sp == DEPTH) is representable without wrap.
    localparam int unsigned PTR_W_DEFAULT = $clog2(DEPTH_DEFAULT) + 1;

    typedef enum logic [1:0] {
        STK_NONE = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10,
        STK_SWAP = 2'b11
    } stk_op_e;

    // Fold the two write-control strobes into a single operation code.
    function automatic stk_op_e stk_op(input logic push, input logic pop);
        stk_op_e op;
        unique case ({pop, push})
            2'b01:   op = STK_PUSH;
            2'b10:   op = STK_POP;
            2'b11:   op = STK_SWAP;
            default: op = STK_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x AW register array backing the return-address stack.
//   clk   : write clock
//   we    : write enable, waddr/wdata sampled on rising edge
//   raddr : asynchronous read index, rdata is mem[raddr]
// No reset: the owning pointer decides which entries are meaningful.
module stack_ram #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [AW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [AW-1:0]            rdata
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack_unit.sv
// Hardware return-address stack fed by write-control push/pop strobes.
//   clk, rst_n           : clock, async active-low reset
//   StackPush, PushAddr  : push PushAddr (PC+1) this cycle
//   StackPop             : pop top into RetAddr; RetValid pulses next cycle
//   Flush                : synchronous clear of pointer and flags (RetAddr kept)
//   RetAddr, RetValid    : last popped address and its one-cycle valid
//   TopAddr              : current top entry, 0 when empty
//   Count, Empty, Full   : occupancy status
//   Overflow, Underflow  : sticky error flags
module return_stack_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       StackPush,
    input  logic                       StackPop,
    input  logic [AW-1:0]              PushAddr,
    input  logic                       Flush,
    output logic [AW-1:0]              RetAddr,
    output logic                       RetValid,
    output logic [AW-1:0]              TopAddr,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Empty,
    output logic                       Full,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] sp_q, sp_d;
    logic [AW-1:0] ret_addr_q, ret_addr_d;
    logic          ret_valid_q, ret_valid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          ram_we;
    logic [IW-1:0] ram_waddr;
    logic [IW-1:0] top_idx;
    logic [AW-1:0] top_raw;
    logic          empty, full;
    stk_op_e       op;

    assign op      = stk_op(StackPush, StackPop);
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == PW'(DEPTH));
    // Wraps to DEPTH-1 when empty; TopAddr masks that case below.
    assign top_idx = sp_q[IW-1:0] - IW'(1);

    stack_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_stack_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (PushAddr),
        .raddr (top_idx),
        .rdata (top_raw)
    );

    always_comb begin
        sp_d        = sp_q;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        ram_we      = 1'b0;
        ram_waddr   = sp_q[IW-1:0];

        if (Flush) begin
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            unique case (op)
                STK_PUSH: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                        sp_d   = sp_q + PW'(1);
                    end
                end
                STK_POP: begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        ret_addr_d  = top_raw;
                        ret_valid_d = 1'b1;
                        sp_d        = sp_q - PW'(1);
                    end
                end
                STK_SWAP: begin
                    ram_we = 1'b1;
                    if (empty) begin
                        // Pop fails but the push still lands in slot 0.
                        unf_d = 1'b1;
                        sp_d  = PW'(1);
                    end else begin
                        // Replace the top in place; legal even when full.
                        ram_waddr   = top_idx;
                        ret_addr_d  = top_raw;
                        ret_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q        <= '0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign RetAddr   = ret_addr_q;
    assign RetValid  = ret_valid_q;
    assign TopAddr   = empty ? '0 : top_raw;
    assign Count     = CW'(sp_q);
    assign Empty     = empty;
    assign Full      = full;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule

// File: tb/tb_return_stack_unit.sv
// Scoreboard bench for return_stack_unit: a queue-based LIFO model predicts
// popped addresses (checked by an independent monitor on RetValid) and status.
module tb_return_stack_unit;

    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          StackPush = 1'b0;
    logic          StackPop = 1'b0;
    logic [AW-1:0] PushAddr = '0;
    logic          Flush = 1'b0;
    logic [AW-1:0] RetAddr;
    logic          RetValid;
    logic [AW-1:0] TopAddr;
    logic [CW-1:0] Count;
    logic          Empty;
    logic          Full;
    logic          Overflow;
    logic          Underflow;

    return_stack_unit #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StackPush (StackPush),
        .StackPop  (StackPop),
        .PushAddr  (PushAddr),
        .Flush     (Flush),
        .RetAddr   (RetAddr),
        .RetValid  (RetValid),
        .TopAddr   (TopAddr),
        .Count     (Count),
        .Empty     (Empty),
        .Full      (Full),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain LIFO queue plus flags.
    logic [AW-1:0] mdl[$];
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] m_ret = '0;
    bit            m_ovf = 0;
    bit            m_unf = 0;
    bit            m_rv  = 0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl.delete();
        exp_q.delete();
        m_ret = '0;
        m_ovf = 0;
        m_unf = 0;
        m_rv  = 0;
    endtask

    task automatic check_status(input string tag);
        logic [AW-1:0] top;
        top = (mdl.size() == 0) ? '0 : mdl[mdl.size() - 1];
        check({tag, ".Count"},     AW'(Count),     AW'(mdl.size()));
        check({tag, ".Empty"},     AW'(Empty),     AW'(mdl.size() == 0));
        check({tag, ".Full"},      AW'(Full),      AW'(mdl.size() == DEPTH));
        check({tag, ".Overflow"},  AW'(Overflow),  AW'(m_ovf));
        check({tag, ".Underflow"}, AW'(Underflow), AW'(m_unf));
        check({tag, ".RetValid"},  AW'(RetValid),  AW'(m_rv));
        check({tag, ".RetAddr"},   RetAddr,        m_ret);
        check({tag, ".TopAddr"},   TopAddr,        top);
    endtask

    // Called at a negedge; drives one cycle of strobes, updates the model,
    // returns at the following negedge with strobes cleared.
    task automatic step(input string tag, input bit push, input bit pop, input bit flush,
                        input logic [AW-1:0] addr);
        StackPush = push;
        StackPop  = pop;
        Flush     = flush;
        PushAddr  = addr;
        @(posedge clk);
        m_rv = 0;
        if (flush) begin
            mdl.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (push && pop) begin
            if (mdl.size() == 0) begin
                m_unf = 1;
                mdl.push_back(addr);
            end else begin
                m_ret = mdl[mdl.size() - 1];
                mdl[mdl.size() - 1] = addr;
                exp_q.push_back(m_ret);
                m_rv = 1;
            end
        end else if (push) begin
            if (mdl.size() == DEPTH) m_ovf = 1;
            else mdl.push_back(addr);
        end else if (pop) begin
            if (mdl.size() == 0) begin
                m_unf = 1;
            end else begin
                m_ret = mdl.pop_back();
                exp_q.push_back(m_ret);
                m_rv = 1;
            end
        end
        @(negedge clk);
        StackPush = 0;
        StackPop  = 0;
        Flush     = 0;
        check_status(tag);
    endtask

    // Monitor: every RetValid pulse must match the oldest predicted pop.
    always @(negedge clk) begin
        if (rst_n && RetValid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mon_spurious: RetValid=1 with RetAddr 0x%0h, expected no pop",
                         RetAddr);
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                if (RetAddr !== e) begin
                    n_fail++;
                    $display("FAIL mon_retaddr: got 0x%0h expected 0x%0h", RetAddr, e);
                end
            end
        end
    end

    initial begin
        // Reset asserted mid-cycle.
        #3 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_status("reset");

        // Simple LIFO order.
        step("push10", 1, 0, 0, 32'h10);
        step("push20", 1, 0, 0, 32'h20);
        step("push30", 1, 0, 0, 32'h30);
        for (int i = 0; i < 3; i++) step("lifo_pop", 0, 1, 0, '0);

        // Fill, then overflow.
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 32'h100 + i);
        step("overflow", 1, 0, 0, 32'h999);
        step("pop_after_full", 0, 1, 0, '0);
        step("flush_a", 0, 0, 1, '0);

        // Underflow keeps RetAddr.
        step("push55", 1, 0, 0, 32'h55);
        step("pop55", 0, 1, 0, '0);
        step("underflow", 0, 1, 0, '0);
        step("flush_b", 0, 0, 1, '0);

        // Simultaneous push+pop, non-empty then empty.
        step("pushA", 1, 0, 0, 32'hA);
        step("pushB", 1, 0, 0, 32'hB);
        step("swapC", 1, 1, 0, 32'hC);
        step("flush_c", 0, 0, 1, '0);
        step("swap_empty", 1, 1, 0, 32'hC);
        step("flush_d", 0, 0, 1, '0);

        // Swap while full: no overflow.
        for (int i = 0; i < DEPTH; i++) step("fill2", 1, 0, 0, 32'h200 + i);
        step("swap_full", 1, 1, 0, 32'h2FF);
        step("flush_e", 0, 0, 1, '0);

        // Flush overriding a pop on a non-empty stack.
        step("pushF", 1, 0, 0, 32'hF0);
        step("flush_pop", 0, 1, 1, '0);

        // Reset during a push strobe.
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 0, 32'h300 + i);
        StackPush = 1'b1;
        PushAddr  = 32'h3FF;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid.Count", AW'(Count), '0);
        check("rst_mid.Empty", AW'(Empty), 32'd1);
        @(negedge clk);
        StackPush = 1'b0;
        rst_n = 1'b1;
        check_status("rst_mid_rel");
        step("pop_after_rst", 0, 1, 0, '0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 3)       step("rnd", 0, 0, 1, $urandom);
            else if (r < 50) step("rnd", 1, 0, 0, $urandom);
            else if (r < 78) step("rnd", 0, 1, 0, $urandom);
            else if (r < 93) step("rnd", 1, 1, 0, $urandom);
            else             step("rnd", 0, 0, 0, $urandom);
        end

        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_pops: %0d predicted pops never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
